// File: rtl/homing_sequencer.sv
// Endstop homing sequencer for one axis per run: arm, seek, optional second touch, latch.
// Define HOMING_DOUBLE_TOUCH_EN to build the back-off / settle / slow-seek second touch.
module homing_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic [1:0]       axis,
  input  logic             trigger_level,
  input  logic [CNT_W-1:0] phase_timeout,
  input  logic             es_signal,
  input  logic [63:0]      es_pos,
  input  logic             move_busy,
  output logic [1:0]       mux_select,
  output logic             abort_polarity,
  output logic             abort_enabled,
  output logic             unlock,
  output logic             move_req,
  output logic             move_dir,
  output logic             move_slow,
  output logic             move_abort,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       err_code,
  output logic [63:0]      home_pos,
  output logic [3:0]       dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ARM       = 4'd1,
    S_FAST_SEEK = 4'd2,
    S_BACKOFF   = 4'd3,
    S_SETTLE    = 4'd4,
    S_SLOW_SEEK = 4'd5,
    S_LATCH     = 4'd6,
    S_DONE      = 4'd7,
    S_ERROR     = 4'd8
  } state_e;

`ifdef HOMING_DOUBLE_TOUCH_EN
  localparam state_e FIRST_TRIP_NEXT = S_BACKOFF;
`else
  localparam state_e FIRST_TRIP_NEXT = S_LATCH;
`endif

  // Executor handshake: move_req is a one-cycle request; the move is finished once
  // move_busy has been seen high and then reads low. move_abort is a one-cycle stop.
  state_e           state_q, state_d;
  logic [1:0]       axis_q, axis_d;
  logic             trig_q, trig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_busy_q, seen_busy_d;
  logic             tripped_q, tripped_d;
  logic [1:0]       mux_q, mux_d;
  logic             abort_en_q, abort_en_d;
  logic             unlock_q, unlock_d;
  logic             move_req_q, move_req_d;
  logic             dir_q, dir_d;
  logic             slow_q, slow_d;
  logic             move_abort_q, move_abort_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [63:0]      home_pos_q, home_pos_d;
`ifdef HOMING_DOUBLE_TOUCH_EN
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
`endif

  logic move_done, es_trip, trip, in_move, active, timeout_hit, next_is_move;

  always_comb begin
    state_d      = state_q;
    axis_d       = axis_q;
    trig_d       = trig_q;
    cnt_d        = cnt_q;
    seen_busy_d  = seen_busy_q;
    tripped_d    = tripped_q;
    mux_d        = mux_q;
    unlock_d     = 1'b0;
    dir_d        = dir_q;
    slow_d       = slow_q;
    move_abort_d = 1'b0;
    err_code_d   = err_code_q;
    home_pos_d   = home_pos_q;
`ifdef HOMING_DOUBLE_TOUCH_EN
    settle_cnt_d = '0;
`endif

    move_done   = seen_busy_q && !move_busy;
    es_trip     = (es_signal == trig_q);
    trip        = tripped_q || es_trip;
    in_move     = (state_q == S_FAST_SEEK) || (state_q == S_BACKOFF) ||
                  (state_q == S_SLOW_SEEK);
    active      = (state_q != S_IDLE) && (state_q != S_ERROR);
    timeout_hit = in_move && (phase_timeout != '0) &&
                  (cnt_q == phase_timeout - CNT_W'(1));

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          axis_d = axis;
          trig_d = trigger_level;
          if (axis == 2'd0) begin
            state_d    = S_ERROR;
            err_code_d = 3'd1;
          end else begin
            state_d    = S_ARM;
            err_code_d = 3'd0;
          end
        end
      end
      S_ARM: state_d = es_trip ? FIRST_TRIP_NEXT : S_FAST_SEEK;
      S_FAST_SEEK: begin
        if (move_done) begin
          if (trip) begin
            state_d = FIRST_TRIP_NEXT;
          end else begin
            state_d    = S_ERROR;
            err_code_d = 3'd3;
          end
        end
      end
`ifdef HOMING_DOUBLE_TOUCH_EN
      S_BACKOFF: begin
        if (move_done) begin
          if (es_trip) begin
            state_d    = S_ERROR;
            err_code_d = 3'd4;
          end else begin
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        settle_cnt_d = settle_cnt_q + CNT_W'(1);
        if (settle_cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d  = S_SLOW_SEEK;
          unlock_d = 1'b1;
        end
      end
      S_SLOW_SEEK: begin
        if (move_done) begin
          if (trip) begin
            state_d = S_LATCH;
          end else begin
            state_d    = S_ERROR;
            err_code_d = 3'd3;
          end
        end
      end
`endif
      S_LATCH: begin
        home_pos_d = es_pos;
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (timeout_hit) begin
      state_d      = S_ERROR;
      err_code_d   = 3'd2;
      move_abort_d = 1'b1;
    end
    // Cancel is applied last so it outranks a timeout in the same cycle.
    if (cancel && active) begin
      state_d      = S_ERROR;
      err_code_d   = 3'd5;
      move_abort_d = 1'b1;
    end

    if (state_d == S_ERROR) begin
      mux_d      = 2'd0;
      unlock_d   = 1'b0;
      home_pos_d = home_pos_q;
    end
    if (state_d == S_ARM) begin
      mux_d    = axis_d;
      unlock_d = 1'b1;
    end

    if (state_d != state_q) begin
      cnt_d       = '0;
      seen_busy_d = 1'b0;
      tripped_d   = 1'b0;
`ifdef HOMING_DOUBLE_TOUCH_EN
      settle_cnt_d = '0;
`endif
    end else if (in_move) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (move_busy) seen_busy_d = 1'b1;
      if (es_trip)   tripped_d   = 1'b1;
    end

    next_is_move = (state_d == S_FAST_SEEK) || (state_d == S_BACKOFF) ||
                   (state_d == S_SLOW_SEEK);
    move_req_d   = next_is_move && (state_d != state_q);
    if (move_req_d) begin
      dir_d  = (state_d != S_BACKOFF);
      slow_d = (state_d == S_SLOW_SEEK);
    end

    abort_en_d = (state_d == S_FAST_SEEK) || (state_d == S_SLOW_SEEK);
    busy_d     = (state_d != S_IDLE) && (state_d != S_ERROR);
    error_d    = (state_d == S_ERROR);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      axis_q       <= 2'd0;
      trig_q       <= 1'b0;
      cnt_q        <= '0;
      seen_busy_q  <= 1'b0;
      tripped_q    <= 1'b0;
      mux_q        <= 2'd0;
      abort_en_q   <= 1'b0;
      unlock_q     <= 1'b0;
      move_req_q   <= 1'b0;
      dir_q        <= 1'b0;
      slow_q       <= 1'b0;
      move_abort_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 3'd0;
      home_pos_q   <= 64'd0;
`ifdef HOMING_DOUBLE_TOUCH_EN
      settle_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      axis_q       <= axis_d;
      trig_q       <= trig_d;
      cnt_q        <= cnt_d;
      seen_busy_q  <= seen_busy_d;
      tripped_q    <= tripped_d;
      mux_q        <= mux_d;
      abort_en_q   <= abort_en_d;
      unlock_q     <= unlock_d;
      move_req_q   <= move_req_d;
      dir_q        <= dir_d;
      slow_q       <= slow_d;
      move_abort_q <= move_abort_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      home_pos_q   <= home_pos_d;
`ifdef HOMING_DOUBLE_TOUCH_EN
      settle_cnt_q <= settle_cnt_d;
`endif
    end
  end

  assign mux_select     = mux_q;
  assign abort_polarity = trig_q;
  assign abort_enabled  = abort_en_q;
  assign unlock         = unlock_q;
  assign move_req       = move_req_q;
  assign move_dir       = dir_q;
  assign move_slow      = slow_q;
  assign move_abort     = move_abort_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign err_code       = err_code_q;
  assign home_pos       = home_pos_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/homing_sequencer.md
# homing_sequencer

Sequences one endstop homing cycle per axis: configures the endstop mux and abort gating, issues seek and back-off moves to the motion executor, and latches the debounced trip position. It sits between the host register block and the endstop/debounce channel plus motion executor. One instance serves all three axes, selected per run.

## Interface
- SETTLE_CYCLES, 1000: idle cycles between back-off completion and slow seek.
- CNT_W, 32: width of phase and settle counters.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE or ERROR.
- cancel  in  1  abort the run in progress.
- axis  in  2  1=x, 2=y, 3=z; 0 is illegal.
- trigger_level  in  1  endstop level meaning "tripped".
- phase_timeout  in  CNT_W  per-phase cycle limit; 0 disables.
- es_signal  in  1  debounced endstop level.
- es_pos  in  64  position latched by debounce at first edge after unlock.
- move_busy  in  1  motion executor running a move.
- mux_select  out  2  endstop position mux select.
- abort_polarity  out  1  equals latched trigger_level.
- abort_enabled  out  1  endstop may abort motion.
- unlock  out  1  one-cycle pulse re-arming the debounce latch.
- move_req  out  1  one-cycle move request.
- move_dir  out  1  1 = toward endstop.
- move_slow  out  1  1 = slow seek speed.
- move_abort  out  1  one-cycle pulse stopping the current move.
- busy  out  1  high outside IDLE/ERROR.
- done  out  1  one-cycle completion pulse.
- error  out  1  high in ERROR.
- err_code  out  3  0 none, 1 bad axis, 2 timeout, 3 no trigger, 4 stuck, 5 cancelled.
- home_pos  out  64  latched home position.

## Operation
- States: IDLE, ARM, FAST_SEEK, BACKOFF, SETTLE, SLOW_SEEK, LATCH, DONE, ERROR.
- IDLE/ERROR + start: latch axis and trigger_level. If axis==0, go to ERROR with code 1; otherwise go to ARM and clear err_code.
- ARM (1 cycle): mux_select=axis, pulse unlock.
  - es_signal==trigger_level: go to BACKOFF (already on switch).
  - Otherwise: go to FAST_SEEK.
- Move phases: pulse move_req on the entry cycle. Set seen_busy when move_busy=1. The move is complete when seen_busy && !move_busy.
- FAST_SEEK: abort_enabled=1, dir=1, slow=0.
  - Complete with trip: go to BACKOFF.
  - Complete without trip: go to ERROR, code 3.
- BACKOFF: abort_enabled=0, dir=0, slow=0.
  - Complete and es_signal still tripped: go to ERROR, code 4.
  - Otherwise: go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then go to SLOW_SEEK and pulse unlock on the same transition.
- SLOW_SEEK: abort_enabled=1, dir=1, slow=1. Complete with trip goes to LATCH; otherwise ERROR, code 3.
- LATCH: home_pos<=es_pos, then go to DONE.
- DONE: pulse done, then go to IDLE.
- ERROR: mux_select=0, abort_enabled=0; err_code holds until the next accepted start.
- Phase counter: resets on every state entry and increments in the move phases. If phase_timeout!=0 and the count reaches phase_timeout: pulse move_abort, go to ERROR with code 2.
- cancel in any busy state: pulse move_abort, go to ERROR with code 5. cancel is ignored in IDLE/ERROR.

## Timing
- Reset values: all outputs 0, home_pos=0, state IDLE.
- Registered outputs; start to unlock pulse is 1 cycle (ARM).
- move_req asserts the cycle after state entry, exactly one cycle wide.
- Simultaneous events:
  - cancel and timeout: cancel wins.
  - cancel and start in IDLE: start is accepted.
  - start while busy: ignored.
- Trip and move completion in the same cycle count as a trip.
- Reset mid-run: returns to IDLE next edge with no move_abort pulse. The system reset also stops the executor.
- IDLE start to done, with immediate trip and zero-length moves, takes at least 8 + SETTLE_CYCLES cycles.

## Configuration
- HOMING_DOUBLE_TOUCH_EN defined: full sequence with BACKOFF, SETTLE, SLOW_SEEK.
- HOMING_DOUBLE_TOUCH_EN undefined: FAST_SEEK trip goes directly to LATCH. The ARM already-tripped case goes to LATCH without moving. The BACKOFF, SETTLE and SLOW_SEEK states and the settle counter are not built, and err_code 4 never occurs.

## Test plan
- Normal run: axis=2, trigger_level=1. Executor busy 20 cycles per move, es_signal rises during fast seek and again during slow seek, es_pos=0x1234. Required: mux_select=2, two unlock pulses, three move_req pulses with (dir,slow)=(1,0),(0,0),(1,1), home_pos=0x1234, one done pulse, err_code=0.
- axis=0 start: next cycle error=1, err_code=1, no move_req.
- Seek move completes without trip: ERROR, err_code=3, abort_enabled=0.
- phase_timeout=50 with move_busy held high: move_abort pulses at cycle 50 of FAST_SEEK, err_code=2.
- es_signal stuck tripped through back-off: err_code=4. Separately, cancel during SETTLE: move_abort pulse, err_code=5; a following start clears the error and a full run completes.
